mem_addr_unit: RTL

Parametrised memory-address unit in front of the CPU's unified memory port. Selects the memory address from N_SRC datapath sources (PC, ALUOut, …), and on an exception request runs a multicycle vector fetch: it presents the fixed vector-table address for the cause, waits the memory latency, and captures the zero-extended handler address for the PC. It replaces the fixed-width IorD selector and moves vector sequencing out of the control unit.

---
 rtl/mem_addr_pkg.sv | 14 +
 rtl/addr_src_mux.sv | 20 ++
 rtl/mem_addr_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_addr_pkg.sv
// Shared types and defaults for the memory-address unit.
// Holds the vector-fetch state encoding and the default vector-table geometry.
package mem_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_VEC_BASE = 253;
  localparam int DEF_VEC_W    = 8;

endpackage

// File: rtl/addr_src_mux.sv
// Parametrised one-level address-source mux.
// A select value that names no existing source yields all zeros.
module addr_src_mux #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 32,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] data,
  output logic [WIDTH-1:0]       out
);

  always_comb begin
    out = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) out = data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mem_addr_unit.sv
// Memory-address unit: selects the normal memory address from the datapath
// sources and sequences the multicycle exception-vector fetch.
module mem_addr_unit
  import mem_addr_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_SRC    = 4,
  parameter int N_CAUSE  = 3,
  parameter int VEC_BASE = DEF_VEC_BASE,
  parameter int VEC_W    = DEF_VEC_W,
  parameter int MEM_LAT  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(N_SRC)-1:0]       src_sel,
  input  logic [N_SRC*WIDTH-1:0]         src_data,
  input  logic                           exc_req,
  input  logic [$clog2(N_CAUSE+1)-1:0]   exc_cause,
  input  logic [WIDTH-1:0]               mem_rdata,
  output logic [WIDTH-1:0]               mem_addr,
  output logic                           exc_busy,
  output logic                           exc_done,
  output logic                           exc_illegal,
  output logic [WIDTH-1:0]               handler_addr,
  output logic [$clog2(N_CAUSE+1)-1:0]   cause_q
);

  localparam int SEL_W   = $clog2(N_SRC);
  localparam int CAUSE_W = $clog2(N_CAUSE+1);
  localparam logic [CAUSE_W-1:0] CAUSE_LIM = CAUSE_W'(N_CAUSE);

  state_t             state;
  logic [2:0]         cnt;
  logic               illegal_q;
  logic [WIDTH-1:0]   mux_addr;
  logic [WIDTH-1:0]   vec_addr;
  logic               unused_rdata;

  addr_src_mux #(
    .N_SRC (N_SRC),
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_src_mux (
    .sel  (src_sel),
    .data (src_data),
    .out  (mux_addr)
  );

  // Only the low VEC_W bits of a table entry carry the handler address.
  assign unused_rdata = ^mem_rdata;

  assign vec_addr = WIDTH'(VEC_BASE) + WIDTH'(cause_q);
  assign mem_addr = (state == IDLE) ? mux_addr : vec_addr;

  assign exc_busy    = (state != IDLE);
  assign exc_done    = (state == DONE);
  assign exc_illegal = illegal_q;

  // cnt counts remaining wait cycles; the entry is captured when it reaches zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      handler_addr <= '0;
      cause_q      <= '0;
      illegal_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_req) begin
            if (exc_cause < CAUSE_LIM) begin
              cause_q <= exc_cause;
              cnt     <= 3'(MEM_LAT);
              state   <= WAIT;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            handler_addr <= WIDTH'(mem_rdata[VEC_W-1:0]);
            state        <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
